// File: rtl/ascon_dec_pkg.sv
// Shared types and constants for the Ascon decryption controller.
// Holds the state encoding, the round indices that close each phase, and a
// helper that identifies the states waiting for input data.
package ascon_dec_pkg;

    typedef enum logic [4:0] {
        IDLE      = 5'd0,
        CONF_INIT = 5'd1,
        INIT      = 5'd2,
        END_INIT  = 5'd3,
        IDLE_DA   = 5'd4,
        INIT_DA   = 5'd5,
        DA        = 5'd6,
        END_DA    = 5'd7,
        IDLE_CT   = 5'd8,
        INIT_CT   = 5'd9,
        CT        = 5'd10,
        END_CT    = 5'd11,
        IDLE_FIN  = 5'd12,
        INIT_FIN  = 5'd13,
        FIN       = 5'd14,
        END_FIN   = 5'd15,
        CHECK_TAG = 5'd16
    } dec_state_e;

    // Every phase ends on round 11, so the round before it triggers the hand-off
    // to the END_x state.
    localparam logic [3:0] LAST_ROUND   = 4'd11;
    localparam logic [3:0] PENULT_ROUND = 4'd10;

    // States that request a data word from the host.
    function automatic logic is_wait_state(input dec_state_e s);
        return (s == IDLE_DA) || (s == IDLE_CT) || (s == IDLE_FIN);
    endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Round index counter for the Ascon permutation.
// A load takes priority over counting so the FSM can preset the first round
// of the next phase while it is still waiting for data.
module ascon_round_counter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [3:0] i_load_value,
    input  logic       i_enable,
    output logic [3:0] o_count
);

    logic [3:0] r_count;

    // preset or advance the round index
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ascon_decrypt_fsm.sv
// Control FSM for Ascon authenticated decryption.
// Sequences init, one associated-data block, NB_BLOCKS-1 ciphertext blocks and
// the finalisation block (which also carries the last ciphertext word), then
// registers the verdict of the external tag comparator.
// Optional build macro: ASCON_DEC_TIMEOUT_EN adds a wait-state timeout of
// TIMEOUT_CYCLES cycles; without it the FSM waits for data indefinitely.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for i_start
//   CONF_INIT | load IV||K||N into the state register
//   INIT      | init permutation, rounds 0..10
//   END_INIT  | round 11, key XOR at the end
//   IDLE_DA   | waiting for the associated-data word
//   INIT_DA   | absorb AD, first round of the block
//   DA        | AD rounds up to 10
//   END_DA    | round 11, domain-separation bit XOR
//   IDLE_CT   | waiting for a ciphertext word
//   INIT_CT   | replace x0 with C, emit plaintext, first round
//   CT        | ciphertext rounds up to 10
//   END_CT    | round 11, count the finished block
//   IDLE_FIN  | waiting for the last ciphertext word
//   INIT_FIN  | replace x0, emit plaintext, key XOR, first final round
//   FIN       | finalisation rounds up to 10
//   END_FIN   | round 11, key XOR, capture computed tag
//   CHECK_TAG | register comparator verdict, pulse done
module ascon_decrypt_fsm
    import ascon_dec_pkg::*;
#(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6,
    parameter int NB_BLOCKS   = 4
`ifdef ASCON_DEC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         i_sys_enable,
    input  logic                         i_start,
    input  logic                         i_data_valid,
    input  logic                         i_tag_match,
    output logic                         o_ready,
    output logic [3:0]                   o_round_count,
    output logic [$clog2(NB_BLOCKS)-1:0] o_block_count,
    output logic                         o_mux_select,
    output logic                         o_enable_state_reg,
    output logic                         o_enable_xor_data_begin,
    output logic                         o_enable_xor_key_begin,
    output logic                         o_enable_xor_key_end,
    output logic                         o_enable_xor_lsb_end,
    output logic                         o_replace_data,
    output logic                         o_enable_plain_reg,
    output logic                         o_valid_plain,
    output logic                         o_enable_tag_reg,
    output logic                         o_done,
    output logic                         o_auth_ok,
    output logic                         o_auth_fail,
    output logic                         o_timeout
);

    localparam int BC_W = $clog2(NB_BLOCKS);
    localparam logic [BC_W-1:0] LAST_CT_BLOCK = BC_W'(NB_BLOCKS - 2);
    // First round of a phase of R rounds is 12-R.
    localparam logic [3:0] LOAD_A = LAST_ROUND + 4'd1 - 4'(NB_ROUNDS_A);
    localparam logic [3:0] LOAD_B = LAST_ROUND + 4'd1 - 4'(NB_ROUNDS_B);

    dec_state_e      r_state;
    dec_state_e      w_next_state;
    logic [BC_W-1:0] r_block_count;
    logic            r_auth_ok;
    logic            r_auth_fail;
    logic            w_timeout;
    logic            w_cnt_load;
    logic            w_cnt_enable;
    logic [3:0]      w_cnt_load_value;
    logic [3:0]      w_round_count;

    ascon_round_counter u_round_counter (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_load       (w_cnt_load),
        .i_load_value (w_cnt_load_value),
        .i_enable     (w_cnt_enable),
        .o_count      (w_round_count)
    );

`ifdef ASCON_DEC_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] r_wait_count;

    // count consecutive idle cycles spent waiting for data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_count <= '0;
        end else if (!i_sys_enable || !is_wait_state(r_state) || i_data_valid) begin
            r_wait_count <= '0;
        end else begin
            r_wait_count <= r_wait_count + WAIT_W'(1);
        end
    end

    assign w_timeout = i_sys_enable && is_wait_state(r_state) && !i_data_valid &&
                       (r_wait_count == WAIT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // state, block counter and sticky authentication flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_block_count <= '0;
            r_auth_ok     <= 1'b0;
            r_auth_fail   <= 1'b0;
        end else if (!i_sys_enable) begin
            r_state       <= IDLE;
            r_block_count <= '0;
            r_auth_ok     <= 1'b0;
            r_auth_fail   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && i_start) begin
                r_auth_ok   <= 1'b0;
                r_auth_fail <= 1'b0;
            end
            if (r_state == END_CT) begin
                r_block_count <= r_block_count + BC_W'(1);
            end
            if (r_state == CHECK_TAG) begin
                r_block_count <= '0;
                r_auth_ok     <= i_tag_match;
                r_auth_fail   <= !i_tag_match;
            end
            if (w_timeout) begin
                r_block_count <= '0;
                r_auth_ok     <= 1'b0;
                r_auth_fail   <= 1'b1;
            end
        end
    end

    // next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (i_start) w_next_state = CONF_INIT;
            CONF_INIT: w_next_state = INIT;
            INIT:      if (w_round_count == PENULT_ROUND) w_next_state = END_INIT;
            END_INIT:  w_next_state = IDLE_DA;
            IDLE_DA:   if (i_data_valid) w_next_state = INIT_DA;
            INIT_DA:   w_next_state = (w_round_count == PENULT_ROUND) ? END_DA : DA;
            DA:        if (w_round_count == PENULT_ROUND) w_next_state = END_DA;
            END_DA:    w_next_state = IDLE_CT;
            IDLE_CT:   if (i_data_valid) w_next_state = INIT_CT;
            INIT_CT:   w_next_state = (w_round_count == PENULT_ROUND) ? END_CT : CT;
            CT:        if (w_round_count == PENULT_ROUND) w_next_state = END_CT;
            END_CT:    w_next_state = (r_block_count == LAST_CT_BLOCK) ? IDLE_FIN : IDLE_CT;
            IDLE_FIN:  if (i_data_valid) w_next_state = INIT_FIN;
            INIT_FIN:  w_next_state = (w_round_count == PENULT_ROUND) ? END_FIN : FIN;
            FIN:       if (w_round_count == PENULT_ROUND) w_next_state = END_FIN;
            END_FIN:   w_next_state = CHECK_TAG;
            CHECK_TAG: w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
        if (w_timeout) begin
            w_next_state = IDLE;
        end
    end

    // round counter control: preset the first round while waiting, count in round states
    always_comb begin
        w_cnt_load       = 1'b0;
        w_cnt_load_value = 4'd0;
        w_cnt_enable     = 1'b0;
        if (!i_sys_enable) begin
            w_cnt_load = 1'b1;
        end else begin
            case (r_state)
                IDLE, CONF_INIT, CHECK_TAG: w_cnt_load = 1'b1;
                IDLE_DA, IDLE_CT: begin
                    w_cnt_load       = 1'b1;
                    w_cnt_load_value = LOAD_B;
                end
                IDLE_FIN: begin
                    w_cnt_load       = 1'b1;
                    w_cnt_load_value = LOAD_A;
                end
                INIT, END_INIT, INIT_DA, DA, END_DA, INIT_CT, CT, END_CT,
                INIT_FIN, FIN, END_FIN: w_cnt_enable = 1'b1;
                default: w_cnt_load = 1'b1;
            endcase
        end
    end

    // datapath strobes decoded from the current state
    always_comb begin
        o_ready                 = 1'b0;
        o_mux_select            = 1'b1;
        o_enable_state_reg      = 1'b0;
        o_enable_xor_data_begin = 1'b0;
        o_enable_xor_key_begin  = 1'b0;
        o_enable_xor_key_end    = 1'b0;
        o_enable_xor_lsb_end    = 1'b0;
        o_replace_data          = 1'b0;
        o_enable_plain_reg      = 1'b0;
        o_valid_plain           = 1'b0;
        o_enable_tag_reg        = 1'b0;
        o_done                  = 1'b0;
        case (r_state)
            CONF_INIT: begin
                o_mux_select       = 1'b0;
                o_enable_state_reg = 1'b1;
            end
            INIT, DA, CT, END_CT, FIN: o_enable_state_reg = 1'b1;
            END_INIT: begin
                o_enable_state_reg   = 1'b1;
                o_enable_xor_key_end = 1'b1;
            end
            IDLE_DA, IDLE_CT, IDLE_FIN: o_ready = 1'b1;
            INIT_DA: begin
                o_enable_state_reg      = 1'b1;
                o_enable_xor_data_begin = 1'b1;
            end
            END_DA: begin
                o_enable_state_reg   = 1'b1;
                o_enable_xor_lsb_end = 1'b1;
            end
            INIT_CT: begin
                o_enable_state_reg      = 1'b1;
                o_enable_xor_data_begin = 1'b1;
                o_replace_data          = 1'b1;
                o_enable_plain_reg      = 1'b1;
                o_valid_plain           = 1'b1;
            end
            INIT_FIN: begin
                o_enable_state_reg      = 1'b1;
                o_enable_xor_data_begin = 1'b1;
                o_enable_xor_key_begin  = 1'b1;
                o_replace_data          = 1'b1;
                o_enable_plain_reg      = 1'b1;
                o_valid_plain           = 1'b1;
            end
            END_FIN: begin
                o_enable_state_reg   = 1'b1;
                o_enable_xor_key_end = 1'b1;
                o_enable_tag_reg     = 1'b1;
            end
            CHECK_TAG: o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_round_count = w_round_count;
    assign o_block_count = r_block_count;
    assign o_auth_ok     = r_auth_ok;
    assign o_auth_fail   = r_auth_fail;
    assign o_timeout     = w_timeout;

endmodule

// File: tb/tb_ascon_decrypt_fsm.sv
// Directed bench for ascon_decrypt_fsm: reset values, full decrypt with good
// and bad tag, stalled ciphertext wait, sys_enable abort, optional timeout,
// and asynchronous reset in the middle of a message.
module tb_ascon_decrypt_fsm;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       i_sys_enable;
    logic       i_start;
    logic       i_data_valid;
    logic       i_tag_match;
    logic       o_ready;
    logic [3:0] o_round_count;
    logic [1:0] o_block_count;
    logic       o_mux_select;
    logic       o_enable_state_reg;
    logic       o_enable_xor_data_begin;
    logic       o_enable_xor_key_begin;
    logic       o_enable_xor_key_end;
    logic       o_enable_xor_lsb_end;
    logic       o_replace_data;
    logic       o_enable_plain_reg;
    logic       o_valid_plain;
    logic       o_enable_tag_reg;
    logic       o_done;
    logic       o_auth_ok;
    logic       o_auth_fail;
    logic       o_timeout;

`ifdef ASCON_DEC_TIMEOUT_EN
    localparam int STALL = 10;
`else
    localparam int STALL = 50;
`endif

    ascon_decrypt_fsm #(
        .NB_ROUNDS_A (12),
        .NB_ROUNDS_B (6),
        .NB_BLOCKS   (4)
`ifdef ASCON_DEC_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .i_sys_enable            (i_sys_enable),
        .i_start                 (i_start),
        .i_data_valid            (i_data_valid),
        .i_tag_match             (i_tag_match),
        .o_ready                 (o_ready),
        .o_round_count           (o_round_count),
        .o_block_count           (o_block_count),
        .o_mux_select            (o_mux_select),
        .o_enable_state_reg      (o_enable_state_reg),
        .o_enable_xor_data_begin (o_enable_xor_data_begin),
        .o_enable_xor_key_begin  (o_enable_xor_key_begin),
        .o_enable_xor_key_end    (o_enable_xor_key_end),
        .o_enable_xor_lsb_end    (o_enable_xor_lsb_end),
        .o_replace_data          (o_replace_data),
        .o_enable_plain_reg      (o_enable_plain_reg),
        .o_valid_plain           (o_valid_plain),
        .o_enable_tag_reg        (o_enable_tag_reg),
        .o_done                  (o_done),
        .o_auth_ok               (o_auth_ok),
        .o_auth_fail             (o_auth_fail),
        .o_timeout               (o_timeout)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    int fb_cyc;
    int fb_vp;
    int fb_lsb;
    int fb_keyb;
    int fb_tag;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic sample_strobes();
        fb_vp   += int'(o_valid_plain);
        fb_lsb  += int'(o_enable_xor_lsb_end);
        fb_keyb += int'(o_enable_xor_key_begin);
        fb_tag  += int'(o_enable_tag_reg);
    endtask

    // accepted start, then init phase; o_ready expected 14 cycles after the sampling edge
    task automatic start_msg(input logic valid_early);
        int cyc;
        i_start = 1'b1;
        step();
        i_start      = 1'b0;
        i_data_valid = valid_early;
        check_eq("conf_mux", int'(o_mux_select), 0);
        check_eq("conf_state_en", int'(o_enable_state_reg), 1);
        check_eq("flags_cleared", int'({o_auth_ok, o_auth_fail}), 0);
        cyc = 1;
        while (!o_ready && cyc < 64) begin
            step();
            cyc++;
            if (cyc == 13) begin
                check_eq("end_init_key", int'(o_enable_xor_key_end), 1);
                check_eq("end_init_round", int'(o_round_count), 11);
            end
        end
        check_eq("ready_latency", cyc, 14);
    endtask

    // hand one word to the FSM and follow it until the next request or done
    task automatic feed_block();
        fb_vp = 0; fb_lsb = 0; fb_keyb = 0; fb_tag = 0;
        i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
        fb_cyc = 1;
        sample_strobes();
        while (!o_ready && !o_done && fb_cyc < 64) begin
            step();
            fb_cyc++;
            sample_strobes();
        end
    endtask

    task automatic run_message(input logic tag, input logic valid_early, input int stall);
        int total_vp = 0;
        int bad = 0;
        i_tag_match = tag;
        start_msg(valid_early);
        feed_block();
        check_eq("ad_cycles", fb_cyc, 7);
        check_eq("ad_lsb_end", fb_lsb, 1);
        check_eq("ad_no_plain", fb_vp, 0);
        if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                i_start = (k % 10 == 0);
                step();
                if (o_round_count != 4'd6 || !o_ready || o_block_count != 2'd0 ||
                    o_valid_plain || o_timeout)
                    bad++;
            end
            i_start = 1'b0;
            check_eq("stall_hold", bad, 0);
            check_eq("stall_round", int'(o_round_count), 6);
        end
        for (int i = 0; i < 3; i++) begin
            feed_block();
            total_vp += fb_vp;
            check_eq("ct_cycles", fb_cyc, 7);
            check_eq("ct_block_count", int'(o_block_count), i + 1);
        end
        feed_block();
        total_vp += fb_vp;
        check_eq("fin_cycles", fb_cyc, 13);
        check_eq("fin_key_begin", fb_keyb, 1);
        check_eq("fin_tag_reg", fb_tag, 1);
        check_eq("done_pulse", int'(o_done), 1);
        check_eq("plain_pulses", total_vp, 4);
        step();
        check_eq("done_one_cycle", int'(o_done), 0);
        check_eq("auth_ok", int'(o_auth_ok), int'(tag));
        check_eq("auth_fail", int'(o_auth_fail), int'(!tag));
        check_eq("block_cleared", int'(o_block_count), 0);
    endtask

    initial begin
        reset_n      = 1'b0;
        i_sys_enable = 1'b1;
        i_start      = 1'b0;
        i_data_valid = 1'b0;
        i_tag_match  = 1'b0;
        step();
        step();
        check_eq("rst_mux", int'(o_mux_select), 1);
        check_eq("rst_ready", int'(o_ready), 0);
        check_eq("rst_state_en", int'(o_enable_state_reg), 0);
        check_eq("rst_round", int'(o_round_count), 0);
        check_eq("rst_block", int'(o_block_count), 0);
        check_eq("rst_auth", int'({o_auth_ok, o_auth_fail}), 0);
        check_eq("rst_done", int'(o_done), 0);
        check_eq("rst_timeout", int'(o_timeout), 0);
        reset_n = 1'b1;
        step();

        // data valid while IDLE must not start anything
        i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
        check_eq("idle_ignores_valid", int'(o_enable_state_reg), 0);

        // good tag, with a stalled ciphertext wait
        run_message(1'b1, 1'b0, STALL);
        step();
        step();
        check_eq("auth_ok_sticky", int'(o_auth_ok), 1);

        // flipped ciphertext: comparator reports mismatch; valid held high during init
        run_message(1'b0, 1'b1, 0);

        // sys_enable drop in the second ciphertext block, round 8
        i_tag_match = 1'b1;
        start_msg(1'b0);
        feed_block();
        feed_block();
        check_eq("abort_block_before", int'(o_block_count), 1);
        i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
        check_eq("ct_init_round", int'(o_round_count), 6);
        check_eq("ct_init_plain", int'(o_valid_plain), 1);
        step();
        check_eq("ct_round7", int'(o_round_count), 7);
        step();
        check_eq("ct_round8", int'(o_round_count), 8);
        i_sys_enable = 1'b0;
        step();
        check_eq("abort_state_en", int'(o_enable_state_reg), 0);
        check_eq("abort_ready", int'(o_ready), 0);
        check_eq("abort_round", int'(o_round_count), 0);
        check_eq("abort_block", int'(o_block_count), 0);
        i_sys_enable = 1'b1;
        step();
        check_eq("abort_stays_idle", int'({o_ready, o_enable_state_reg}), 0);

`ifdef ASCON_DEC_TIMEOUT_EN
        begin
            int w;
            start_msg(1'b0);
            w = 1;
            while (!o_timeout && w < 64) begin
                step();
                w++;
            end
            check_eq("timeout_cycle", w, 16);
            step();
            check_eq("timeout_idle", int'({o_ready, o_enable_state_reg}), 0);
            check_eq("timeout_auth_fail", int'(o_auth_fail), 1);
            check_eq("timeout_pulse", int'(o_timeout), 0);
        end
`endif

        // asynchronous reset in the middle of a ciphertext block
        start_msg(1'b0);
        feed_block();
        feed_block();
        i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
        step();
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_mux", int'(o_mux_select), 1);
        check_eq("midrst_state_en", int'(o_enable_state_reg), 0);
        check_eq("midrst_round", int'(o_round_count), 0);
        check_eq("midrst_block", int'(o_block_count), 0);
        check_eq("midrst_ready", int'(o_ready), 0);
        step();
        reset_n = 1'b1;
        step();
        check_eq("midrst_idle", int'({o_ready, o_enable_state_reg}), 0);
        start_msg(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
